// File: rtl/ps2_kbd_tx.sv
// rtl/ps2_kbd_tx.sv - device-side PS/2 keyboard transmitter; PS2_TX_FIFO_EN adds a 4-entry byte FIFO
module ps2_kbd_tx #(
  parameter int FREQ_HZ    = 1000000,
  parameter int PS2_CLK_HZ = 12500,
  parameter int HOLDOFF_US = 50
) (
  input  logic       clk,
  input  logic       reset_i,
  input  logic [7:0] code_i,
  input  logic       strobe_i,
  output logic       ready_o,
  output logic       busy_o,
  output logic       abort_o,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_drive_low_o,
  output logic       ps2_data_drive_low_o
);
  localparam int HALF = FREQ_HZ / (2 * PS2_CLK_HZ);
  localparam int HOLD = FREQ_HZ / 1000000 * HOLDOFF_US;
  localparam int CMAX = (2 * HALF > HOLD) ? 2 * HALF : HOLD;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] HALF_END = CW'(HALF - 1);
  localparam logic [CW-1:0] GAP_END  = CW'(2 * HALF - 1);
  localparam logic [CW-1:0] MID      = CW'(HALF / 2);
  localparam logic [CW-1:0] HOLD_CNT = CW'(HOLD);
  localparam logic [CW-1:0] CNT_MAX  = CW'(CMAX);
  localparam logic [CW-1:0] SYNC_IGN = CW'(3);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_LOW   = 3'd2;
  localparam logic [2:0] S_HIGH  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] hold_cnt;
  logic [3:0]    bit_idx;
  logic [10:0]   tx_shift;
  logic          data_low;
  logic          clk_low;
  logic          clk_s1, clk_s2;
  logic          data_s1, data_s2;
  logic          unused_data;
  logic          accept, hold_ok, have_byte, phase_end, inhibit, done;
  logic [7:0]    src_byte;

  assign unused_data          = data_s2;
  assign ps2_clk_drive_low_o  = clk_low;
  assign ps2_data_drive_low_o = data_low;
  assign accept               = strobe_i && ready_o;
  assign hold_ok              = clk_s2 && (hold_cnt == HOLD_CNT);
  assign done                 = (state == S_GAP) && phase_end;
  assign inhibit              = (state == S_HIGH) && (cnt >= SYNC_IGN) && !clk_s2 && (bit_idx <= 4'd9);

  // end-of-phase detection for the timed states
  always_comb begin
    phase_end = 1'b0;
    case (state)
      S_SETUP, S_LOW, S_HIGH: phase_end = (cnt == HALF_END);
      S_GAP:                  phase_end = (cnt == GAP_END);
      default:                phase_end = 1'b0;
    endcase
  end

  // two-flop synchronizers for the sensed lines; idle lines read high
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
    end else begin
      clk_s1  <= ps2_clk_i;
      clk_s2  <= clk_s1;
      data_s1 <= ps2_data_i;
      data_s2 <= data_s1;
    end
  end

  // counts consecutive idle cycles with the clock line high, saturating at HOLD
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      hold_cnt <= '0;
    end else if (state != S_IDLE || !clk_s2) begin
      hold_cnt <= '0;
    end else if (hold_cnt != HOLD_CNT) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end

  // frame sequencer: setup, 11 low/high clock pulses, trailing gap, abort on host inhibit
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      state    <= S_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      tx_shift <= '0;
      data_low <= 1'b0;
      clk_low  <= 1'b0;
      abort_o  <= 1'b0;
    end else begin
      abort_o <= 1'b0;
      if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
      case (state)
        S_IDLE: begin
          if (have_byte && hold_ok) begin
            state    <= S_SETUP;
            cnt      <= '0;
            bit_idx  <= '0;
            tx_shift <= {1'b1, ~^src_byte, src_byte, 1'b0};
            data_low <= 1'b1;
          end
        end
        S_SETUP: begin
          if (phase_end) begin
            state   <= S_LOW;
            cnt     <= '0;
            clk_low <= 1'b1;
          end
        end
        S_LOW: begin
          if (phase_end) begin
            state   <= S_HIGH;
            cnt     <= '0;
            clk_low <= 1'b0;
          end
        end
        S_HIGH: begin
          if (inhibit) begin
            state    <= S_IDLE;
            cnt      <= '0;
            data_low <= 1'b0;
            abort_o  <= 1'b1;
          end else begin
            if (cnt == MID) begin
              tx_shift <= tx_shift >> 1;
              data_low <= (bit_idx == 4'd10) ? 1'b0 : ~tx_shift[1];
            end
            if (phase_end) begin
              cnt <= '0;
              if (bit_idx < 4'd10) begin
                bit_idx <= bit_idx + 4'd1;
                state   <= S_LOW;
                clk_low <= 1'b1;
              end else begin
                state <= S_GAP;
              end
            end
          end
        end
        S_GAP: begin
          if (phase_end) begin
            state <= S_IDLE;
            cnt   <= '0;
          end
        end
        default: begin
          state    <= S_IDLE;
          data_low <= 1'b0;
          clk_low  <= 1'b0;
        end
      endcase
    end
  end

`ifdef PS2_TX_FIFO_EN
  logic [7:0] fifo_mem [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] fifo_cnt;

  assign ready_o   = reset_i && (fifo_cnt != 3'd4);
  assign busy_o    = (fifo_cnt != 3'd0) || (state != S_IDLE);
  assign have_byte = (fifo_cnt != 3'd0) || accept;
  assign src_byte  = (fifo_cnt != 3'd0) ? fifo_mem[rd_ptr] : code_i;

  // head entry stays until its frame completes, so an aborted byte is resent first
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      for (int i = 0; i < 4; i++) fifo_mem[i] <= '0;
    end else begin
      if (accept) begin
        fifo_mem[wr_ptr] <= code_i;
        wr_ptr           <= wr_ptr + 2'd1;
      end
      if (done) rd_ptr <= rd_ptr + 2'd1;
      fifo_cnt <= fifo_cnt + {2'b00, accept} - {2'b00, done};
    end
  end
`else
  logic       pending;
  logic [7:0] hold_byte;

  assign ready_o   = reset_i && (state == S_IDLE) && !pending;
  assign busy_o    = pending || (state != S_IDLE);
  assign have_byte = pending || accept;
  assign src_byte  = pending ? hold_byte : code_i;

  // single holding register; stays pending through aborts until the frame completes
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      pending   <= 1'b0;
      hold_byte <= '0;
    end else if (accept) begin
      pending   <= 1'b1;
      hold_byte <= code_i;
    end else if (done) begin
      pending <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// tb/tb_ps2_kbd_tx.sv - directed self-checking bench for ps2_kbd_tx
module tb_ps2_kbd_tx;
  localparam int HALF = 40;

  logic       clk = 1'b0;
  logic       reset_i;
  logic [7:0] code;
  logic       strobe, ready, busy, abort, cl, dl;
  logic       host_hold;
  logic       ps2_clk_line, ps2_data_line;
  int         checks = 0;
  int         errors = 0;

  assign ps2_clk_line  = ~(cl | host_hold);
  assign ps2_data_line = ~dl;

  ps2_kbd_tx dut (
    .clk(clk), .reset_i(reset_i), .code_i(code), .strobe_i(strobe),
    .ready_o(ready), .busy_o(busy), .abort_o(abort),
    .ps2_clk_i(ps2_clk_line), .ps2_data_i(ps2_data_line),
    .ps2_clk_drive_low_o(cl), .ps2_data_drive_low_o(dl)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // sends one byte and observes it; k counts clock edges after the accepting edge
  task automatic run_frame(input logic [7:0] b, input int mode,
      output logic [10:0] bits, output int nfall, output int ready_k, output int aborts,
      output int first_dl_k, output int first_cl_k, output int rel_k, output int retx_k,
      output logic lines_at_abort, output logic busy_at_abort, output logic busy_at_ready,
      output int nfall_at_rel);
    logic prev_cl;
    int   fall_k;
    bits = '0; nfall = 0; ready_k = -1; aborts = 0; first_dl_k = -1; first_cl_k = -1;
    rel_k = -1; retx_k = -1; lines_at_abort = 1'b1; busy_at_abort = 1'b0;
    busy_at_ready = 1'b1; nfall_at_rel = -1; fall_k = -1; prev_cl = 1'b0;
    repeat (60) @(negedge clk);
    code = b; strobe = 1'b1;
    @(negedge clk);
    strobe = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      if (k > 0) @(negedge clk);
      if (dl && first_dl_k < 0) first_dl_k = k;
      if (cl && first_cl_k < 0) first_cl_k = k;
      if (rel_k >= 0 && dl && retx_k < 0) retx_k = k;
      if (cl && !prev_cl) begin
        if (nfall < 11) bits[nfall] = ~dl;
        nfall++;
        fall_k = k;
      end
      prev_cl = cl;
      if (abort) begin
        aborts++;
        lines_at_abort = cl | dl;
        busy_at_abort = busy;
        nfall = 0;
        bits = '0;
      end
      if (ready && k > 0) begin
        ready_k = k;
        busy_at_ready = busy;
        break;
      end
      case (mode)
        1: begin
          if (nfall == 5 && !host_hold && rel_k < 0 && aborts == 0 && k == fall_k + HALF + 10)
            host_hold = 1'b1;
          if (host_hold && k == fall_k + HALF + 110) begin
            host_hold = 1'b0;
            rel_k = k;
            nfall_at_rel = nfall;
          end
        end
        2: begin
          if (nfall == 11 && k == fall_k + HALF + 10) host_hold = 1'b1;
          if (nfall == 11 && k == fall_k + HALF + 20) host_hold = 1'b0;
        end
        3: begin
          if (k == 100) begin code = 8'hFF; strobe = 1'b1; end
          if (k == 101) strobe = 1'b0;
        end
        default: ;
      endcase
    end
    host_hold = 1'b0;
    strobe = 1'b0;
  endtask

  task automatic test_reset;
    reset_i = 1'b1; strobe = 1'b0; code = 8'h00; host_hold = 1'b0;
    #2 reset_i = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (cl !== 1'b0) begin errors++; $display("FAIL reset_clk_drive: got %b expected 0", cl); end
    checks++; if (dl !== 1'b0) begin errors++; $display("FAIL reset_data_drive: got %b expected 0", dl); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (abort !== 1'b0) begin errors++; $display("FAIL reset_abort: got %b expected 0", abort); end
    reset_i = 1'b1;
    @(negedge clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b expected 1", ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_frame_1c;
    logic [10:0] bits; int nf, rk, ab, fd, fc, rl, rx, na; logic la, ba, br;
    run_frame(8'h1C, 0, bits, nf, rk, ab, fd, fc, rl, rx, la, ba, br, na);
    checks++; if (bits !== 11'h438) begin errors++; $display("FAIL frame_1c_bits: got %h expected 438", bits); end
    checks++; if (nf !== 11) begin errors++; $display("FAIL frame_1c_falls: got %0d expected 11", nf); end
    checks++; if (fd !== 0) begin errors++; $display("FAIL frame_1c_data_latency: got %0d expected 0", fd); end
    checks++; if (fc !== HALF) begin errors++; $display("FAIL frame_1c_clk_latency: got %0d expected %0d", fc, HALF); end
    checks++; if (rk !== 1000) begin errors++; $display("FAIL frame_1c_ready_latency: got %0d expected 1000", rk); end
    checks++; if (br !== 1'b0) begin errors++; $display("FAIL frame_1c_busy_end: got %b expected 0", br); end
    checks++; if (ab !== 0) begin errors++; $display("FAIL frame_1c_aborts: got %0d expected 0", ab); end
  endtask

  task automatic test_parity;
    logic [10:0] bits; int nf, rk, ab, fd, fc, rl, rx, na; logic la, ba, br;
    run_frame(8'hF0, 0, bits, nf, rk, ab, fd, fc, rl, rx, la, ba, br, na);
    checks++; if (bits !== 11'h7E0) begin errors++; $display("FAIL frame_f0_bits: got %h expected 7e0", bits); end
    checks++; if (rk !== 1000) begin errors++; $display("FAIL frame_f0_ready_latency: got %0d expected 1000", rk); end
    run_frame(8'h00, 0, bits, nf, rk, ab, fd, fc, rl, rx, la, ba, br, na);
    checks++; if (bits !== 11'h600) begin errors++; $display("FAIL frame_00_bits: got %h expected 600", bits); end
    checks++; if (nf !== 11) begin errors++; $display("FAIL frame_00_falls: got %0d expected 11", nf); end
  endtask

  task automatic test_inhibit;
    logic [10:0] bits; int nf, rk, ab, fd, fc, rl, rx, na; logic la, ba, br;
    run_frame(8'h5A, 1, bits, nf, rk, ab, fd, fc, rl, rx, la, ba, br, na);
    checks++; if (ab !== 1) begin errors++; $display("FAIL inhibit_abort_count: got %0d expected 1", ab); end
    checks++; if (la !== 1'b0) begin errors++; $display("FAIL inhibit_lines_released: got %b expected 0", la); end
    checks++; if (ba !== 1'b1) begin errors++; $display("FAIL inhibit_busy_pending: got %b expected 1", ba); end
    checks++; if (na !== 0) begin errors++; $display("FAIL inhibit_quiet_during_hold: got %0d expected 0", na); end
    checks++; if (rx - rl < 51 || rx - rl > 55) begin errors++; $display("FAIL inhibit_holdoff: got %0d expected 51..55", rx - rl); end
    checks++; if (bits !== 11'h6B4) begin errors++; $display("FAIL inhibit_resent_bits: got %h expected 6b4", bits); end
    checks++; if (nf !== 11) begin errors++; $display("FAIL inhibit_resent_falls: got %0d expected 11", nf); end
    checks++; if (rk - rx !== 1000) begin errors++; $display("FAIL inhibit_resent_length: got %0d expected 1000", rk - rx); end
  endtask

  task automatic test_stop_inhibit;
    logic [10:0] bits; int nf, rk, ab, fd, fc, rl, rx, na; logic la, ba, br;
    run_frame(8'h1C, 2, bits, nf, rk, ab, fd, fc, rl, rx, la, ba, br, na);
    checks++; if (ab !== 0) begin errors++; $display("FAIL stop_inhibit_aborts: got %0d expected 0", ab); end
    checks++; if (bits !== 11'h438) begin errors++; $display("FAIL stop_inhibit_bits: got %h expected 438", bits); end
    checks++; if (rk !== 1000) begin errors++; $display("FAIL stop_inhibit_ready_latency: got %0d expected 1000", rk); end
  endtask

`ifdef PS2_TX_FIFO_EN
  task automatic test_fifo;
    logic [7:0]  pushes [5];
    logic [10:0] expv [4];
    logic [10:0] got [4];
    logic        prev_cl;
    int          nfall;
    pushes = '{8'hE0, 8'hF0, 8'h1C, 8'h12, 8'h34};
    expv   = '{11'h5C0, 11'h7E0, 11'h438, 11'h624};
    got    = '{11'h0, 11'h0, 11'h0, 11'h0};
    nfall  = 0;
    repeat (60) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checks++; if (ready !== (i < 4)) begin errors++; $display("FAIL fifo_ready_push%0d: got %b expected %b", i, ready, (i < 4)); end
      code = pushes[i]; strobe = 1'b1;
      @(negedge clk);
    end
    strobe = 1'b0;
    prev_cl = cl;
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk);
      if (cl && !prev_cl) begin
        if (nfall < 44) got[nfall / 11][nfall % 11] = ~dl;
        nfall++;
      end
      prev_cl = cl;
    end
    for (int i = 0; i < 4; i++) begin
      checks++; if (got[i] !== expv[i]) begin errors++; $display("FAIL fifo_frame%0d_bits: got %h expected %h", i, got[i], expv[i]); end
    end
    checks++; if (nfall !== 44) begin errors++; $display("FAIL fifo_total_falls: got %0d expected 44", nfall); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fifo_busy_end: got %b expected 0", busy); end
  endtask
`else
  task automatic test_drop;
    logic [10:0] bits; int nf, rk, ab, fd, fc, rl, rx, na; logic la, ba, br;
    int extra;
    run_frame(8'h1C, 3, bits, nf, rk, ab, fd, fc, rl, rx, la, ba, br, na);
    checks++; if (bits !== 11'h438) begin errors++; $display("FAIL drop_first_bits: got %h expected 438", bits); end
    checks++; if (rk !== 1000) begin errors++; $display("FAIL drop_ready_latency: got %0d expected 1000", rk); end
    extra = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (dl || cl || busy) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL drop_no_second_frame: got %0d active cycles expected 0", extra); end
  endtask
`endif

  task automatic test_reset_mid;
    int active;
    repeat (60) @(negedge clk);
    code = 8'h00; strobe = 1'b1;
    @(negedge clk);
    strobe = 1'b0;
    repeat (300) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midreset_busy_before: got %b expected 1", busy); end
    checks++; if (cl !== 1'b1) begin errors++; $display("FAIL midreset_clk_before: got %b expected 1", cl); end
    checks++; if (dl !== 1'b1) begin errors++; $display("FAIL midreset_data_before: got %b expected 1", dl); end
    #1 reset_i = 1'b0;
    #1;
    checks++; if (cl !== 1'b0) begin errors++; $display("FAIL midreset_clk_async: got %b expected 0", cl); end
    checks++; if (dl !== 1'b0) begin errors++; $display("FAIL midreset_data_async: got %b expected 0", dl); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL midreset_ready: got %b expected 0", ready); end
    @(negedge clk);
    reset_i = 1'b1;
    @(negedge clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL midreset_ready_after: got %b expected 1", ready); end
    active = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (dl || cl || busy) active++;
    end
    checks++; if (active !== 0) begin errors++; $display("FAIL midreset_no_pending: got %0d active cycles expected 0", active); end
  endtask

  initial begin
    test_reset();
    test_frame_1c();
    test_parity();
    test_inhibit();
    test_stop_inhibit();
`ifdef PS2_TX_FIFO_EN
    test_fifo();
`else
    test_drop();
`endif
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
